// File: rtl/atp_txn_ctrl_if.sv
// Bus between the ATP kiosk front panel/peripherals and the transaction controller.
// The slave side is the controller; the master side drives the customer-facing inputs.
interface atp_txn_ctrl_if #(
  parameter int unsigned AMT_W = 16
);
  logic             voucher_placed_i;
  logic             scan_ok_i;
  logic [AMT_W-1:0] bill_due_i;
  logic [1:0]       pay_mode_i;
  logic             pay_mode_valid_i;
  logic             confirm_i;
  logic             tender_valid_i;
  logic [AMT_W-1:0] tender_amt_i;
  logic             validate_ok_i;
  logic             validate_fail_i;
  logic             cancel_i;
  logic             bill_ack_i;

  logic [2:0]       state_o;
  logic [AMT_W-1:0] amount_due_o;
  logic [AMT_W:0]   paid_total_o;
  logic [AMT_W-1:0] change_o;
  logic             print_bill_o;
  logic             refund_o;
  logic             busy_o;
  logic             error_o;

  modport slave (
    input  voucher_placed_i, scan_ok_i, bill_due_i, pay_mode_i, pay_mode_valid_i,
           confirm_i, tender_valid_i, tender_amt_i, validate_ok_i, validate_fail_i,
           cancel_i, bill_ack_i,
    output state_o, amount_due_o, paid_total_o, change_o, print_bill_o, refund_o,
           busy_o, error_o
  );

  modport master (
    output voucher_placed_i, scan_ok_i, bill_due_i, pay_mode_i, pay_mode_valid_i,
           confirm_i, tender_valid_i, tender_amt_i, validate_ok_i, validate_fail_i,
           cancel_i, bill_ack_i,
    input  state_o, amount_due_o, paid_total_o, change_o, print_bill_o, refund_o,
           busy_o, error_o
  );
endinterface

// File: rtl/atp_txn_ctrl.sv
// ATP bill-payment transaction controller: scan, mode select, tender, validation,
// receipt printing and refund, with per-state idle timeout and bounded retries.
module atp_txn_ctrl #(
  parameter int unsigned AMT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  atp_txn_ctrl_if.slave    bus
);
  localparam int unsigned PAID_W = AMT_W + 1;
  localparam int unsigned SUM_W  = PAID_W + 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);
  localparam logic [1:0]  MODE_CASH = 2'b00;
  localparam logic [1:0]  MODE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_SELECT   = 3'd2,
    S_CONFIRM  = 3'd3,
    S_TENDER   = 3'd4,
    S_VALIDATE = 3'd5,
    S_PRINT    = 3'd6,
    S_REFUND   = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [AMT_W-1:0]    due_q, due_d;
  logic [PAID_W-1:0]   paid_q, paid_d;
  logic [AMT_W-1:0]    chg_q, chg_d;
  logic [1:0]          mode_q, mode_d;
  logic [RTY_W-1:0]    rty_q, rty_d, rty_inc;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                print_q, refund_q, busy_q, err_q, err_d;
  logic                accept, abort, tmo_hit, cancel_hit, wait_d;
  logic [SUM_W-1:0]    sum_w;
  logic [PAID_W-1:0]   cash_sum;

  // Cash accumulation saturates at the top of the paid_total range
  assign sum_w    = SUM_W'(paid_q) + SUM_W'(bus.tender_amt_i);
  assign cash_sum = sum_w[PAID_W] ? {PAID_W{1'b1}} : sum_w[PAID_W-1:0];
  assign rty_inc  = rty_q + RTY_W'(1);

  always_comb begin
    state_d    = state_q;
    due_d      = due_q;
    paid_d     = paid_q;
    chg_d      = chg_q;
    mode_d     = mode_q;
    rty_d      = rty_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    cancel_hit = bus.cancel_i &&
                 (state_q inside {S_SCAN, S_SELECT, S_CONFIRM, S_TENDER});
    tmo_hit    = (state_q inside {S_SCAN, S_SELECT, S_CONFIRM, S_TENDER, S_VALIDATE}) &&
                 (tmo_q >= TMO_W'(TIMEOUT_CYC - 1));

    if (cancel_hit) begin
      abort = 1'b1;
    end else if (tmo_hit) begin
      abort = 1'b1;
      err_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.voucher_placed_i) begin
          accept  = 1'b1;
          state_d = S_SCAN;
        end
        S_SCAN: if (bus.scan_ok_i) begin
          accept = 1'b1;
          if (bus.bill_due_i == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            due_d   = bus.bill_due_i;
            state_d = S_SELECT;
          end
        end
        S_SELECT: if (bus.pay_mode_valid_i) begin
          accept = 1'b1;
          if (bus.pay_mode_i == MODE_RSVD) begin
            err_d = 1'b1;
          end else begin
            mode_d  = bus.pay_mode_i;
            state_d = S_CONFIRM;
          end
        end
        S_CONFIRM: if (bus.confirm_i) begin
          accept  = 1'b1;
          state_d = S_TENDER;
        end
        // Cash moves on one cycle after the registered total covers the bill
        S_TENDER: begin
          if (mode_q == MODE_CASH) begin
            if (paid_q >= PAID_W'(due_q)) begin
              state_d = S_VALIDATE;
            end else if (bus.tender_valid_i) begin
              accept = 1'b1;
              paid_d = cash_sum;
            end
          end else if (bus.tender_valid_i) begin
            accept = 1'b1;
            if (bus.tender_amt_i >= due_q) begin
              paid_d  = PAID_W'(bus.tender_amt_i);
              state_d = S_VALIDATE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        // A simultaneous ok+fail verdict is taken as a failure
        S_VALIDATE: begin
          if (bus.validate_fail_i) begin
            accept = 1'b1;
            if (rty_inc >= RTY_W'(MAX_RETRY)) begin
              chg_d   = AMT_W'(paid_q);
              state_d = S_REFUND;
            end else begin
              rty_d   = rty_inc;
              state_d = S_TENDER;
              if (mode_q != MODE_CASH) paid_d = '0;
            end
          end else if (bus.validate_ok_i) begin
            accept  = 1'b1;
            chg_d   = (mode_q == MODE_CASH) ? AMT_W'(paid_q - PAID_W'(due_q)) : '0;
            state_d = S_PRINT;
          end
        end
        S_PRINT: if (bus.bill_ack_i) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
        S_REFUND: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    if (abort) begin
      if (paid_q != '0) begin
        chg_d   = AMT_W'(paid_q);
        state_d = S_REFUND;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Every return to IDLE starts the next customer from a clean slate
    if (state_d == S_IDLE) begin
      due_d  = '0;
      paid_d = '0;
      chg_d  = '0;
      mode_d = '0;
      rty_d  = '0;
    end

    wait_d = (state_d != S_IDLE) && (state_d != S_PRINT) && (state_d != S_REFUND);
    if ((state_d != state_q) || accept || !wait_d) tmo_d = '0;
    else                                             tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      due_q    <= '0;
      paid_q   <= '0;
      chg_q    <= '0;
      mode_q   <= '0;
      rty_q    <= '0;
      tmo_q    <= '0;
      print_q  <= 1'b0;
      refund_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      due_q    <= due_d;
      paid_q   <= paid_d;
      chg_q    <= chg_d;
      mode_q   <= mode_d;
      rty_q    <= rty_d;
      tmo_q    <= tmo_d;
      print_q  <= (state_d == S_PRINT);
      refund_q <= (state_d == S_REFUND);
      busy_q   <= (state_d != S_IDLE);
      err_q    <= err_d;
    end
  end

  assign bus.state_o      = state_q;
  assign bus.amount_due_o = due_q;
  assign bus.paid_total_o = paid_q;
  assign bus.change_o     = chg_q;
  assign bus.print_bill_o = print_q;
  assign bus.refund_o     = refund_q;
  assign bus.busy_o       = busy_q;
  assign bus.error_o      = err_q;
endmodule

// File: tb/tb_atp_txn_ctrl.sv
// Scoreboard bench for atp_txn_ctrl: directed scenarios plus randomized cash,
// card, cheque and cancel transactions checked against an outcome-level model.
module tb_atp_txn_ctrl;
  localparam int unsigned AMT_W = 16;
  localparam int unsigned TMO   = 8;
  localparam int unsigned MAXR  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atp_txn_ctrl_if #(.AMT_W(AMT_W)) bus ();

  atp_txn_ctrl #(.AMT_W(AMT_W), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {EV_ERR, EV_PRINT, EV_REFUND} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    longint   paid;
    longint   chg;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  print_prev = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input ev_kind_e k, input longint p, input longint c);
    ev_t e;
    e.kind = k;
    e.paid = p;
    e.chg  = c;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input ev_kind_e k, input longint paid, input longint chg);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: got kind %0d expected none at %0t", k, $time);
    end else begin
      e = exp_q.pop_front();
      check("event kind", k, e.kind);
      if (e.kind == EV_PRINT && k == EV_PRINT) begin
        check("print paid_total", paid, e.paid);
        check("print change", chg, e.chg);
      end
      if (e.kind == EV_REFUND && k == EV_REFUND) check("refund change", chg, e.chg);
    end
  endtask

  // Monitor: every visible output event is matched against the expected queue
  always @(negedge clk) begin
    if (!rst_n) begin
      print_prev = 1'b0;
    end else begin
      if (bus.error_o)  expect_ev(EV_ERR, 0, 0);
      if (bus.refund_o) expect_ev(EV_REFUND, 0, bus.change_o);
      if (bus.print_bill_o && !print_prev) expect_ev(EV_PRINT, bus.paid_total_o, bus.change_o);
      print_prev = bus.print_bill_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.voucher_placed_i = 1'b0; bus.scan_ok_i = 1'b0; bus.bill_due_i = '0;
    bus.pay_mode_i = '0; bus.pay_mode_valid_i = 1'b0; bus.confirm_i = 1'b0;
    bus.tender_valid_i = 1'b0; bus.tender_amt_i = '0; bus.validate_ok_i = 1'b0;
    bus.validate_fail_i = 1'b0; bus.cancel_i = 1'b0; bus.bill_ack_i = 1'b0;
  endtask

  task automatic wait_state(input int st, input string name);
    int n = 0;
    while (int'(bus.state_o) != st && n < 30) begin
      tick();
      n++;
    end
    check(name, bus.state_o, st);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " state"}, bus.state_o, 0);
    check({tag, " amount_due"}, bus.amount_due_o, 0);
    check({tag, " paid_total"}, bus.paid_total_o, 0);
    check({tag, " change"}, bus.change_o, 0);
    check({tag, " busy"}, bus.busy_o, 0);
  endtask

  task automatic start_txn(input int due, input int mode);
    bus.voucher_placed_i = 1'b1; tick(); bus.voucher_placed_i = 1'b0;
    wait_state(1, "enter scan");
    check("busy in scan", bus.busy_o, 1);
    bus.scan_ok_i = 1'b1; bus.bill_due_i = AMT_W'(due); tick(); bus.scan_ok_i = 1'b0;
    wait_state(2, "enter select");
    check("amount_due latched", bus.amount_due_o, due);
    bus.pay_mode_valid_i = 1'b1; bus.pay_mode_i = 2'(mode); tick(); bus.pay_mode_valid_i = 1'b0;
    wait_state(3, "enter confirm");
  endtask

  task automatic go_tender();
    bus.confirm_i = 1'b1; tick(); bus.confirm_i = 1'b0;
    wait_state(4, "enter tender");
  endtask

  task automatic tender(input int amt);
    bus.tender_valid_i = 1'b1; bus.tender_amt_i = AMT_W'(amt); tick(); bus.tender_valid_i = 1'b0;
  endtask

  task automatic verdict(input bit ok, input bit fail);
    bus.validate_ok_i = ok; bus.validate_fail_i = fail; tick();
    bus.validate_ok_i = 1'b0; bus.validate_fail_i = 1'b0;
  endtask

  task automatic finish_print();
    int h = int'($urandom_range(1, 4));
    check("enter print", bus.state_o, 6);
    repeat (h) begin
      check("print_bill held", bus.print_bill_o, 1);
      tick();
    end
    bus.bill_ack_i = 1'b1; tick(); bus.bill_ack_i = 1'b0;
    check_idle("after print");
    check("print_bill cleared", bus.print_bill_o, 0);
  endtask

  task automatic finish_refund();
    check("refund state", bus.state_o, 7);
    tick();
    check_idle("after refund");
  endtask

  // Cash: bill covered by the running sum; change is the overpayment
  task automatic run_cash(input int due, input int tl[$], input int fails, input bit cancel_val);
    longint sum = 0;
    start_txn(due, 0);
    go_tender();
    foreach (tl[i]) begin
      tender(tl[i]);
      sum += tl[i];
      if (sum < due) repeat ($urandom_range(0, 2)) tick();
    end
    if (sum > 131071) sum = 131071;
    wait_state(5, "cash enter validate");
    check("cash paid_total", bus.paid_total_o, sum);
    if (cancel_val) begin
      bus.cancel_i = 1'b1; tick(); bus.cancel_i = 1'b0;
      check("cancel ignored in validate", bus.state_o, 5);
    end
    for (int f = 0; f < fails; f++) begin
      verdict($urandom_range(0, 1) == 1, 1'b1);
      wait_state(5, "cash retry back to validate");
      check("cash paid kept on retry", bus.paid_total_o, sum);
    end
    push_ev(EV_PRINT, sum, sum - due);
    verdict(1'b1, 1'b0);
    finish_print();
  endtask

  // Cheque/card: one instrument must cover the bill; failures clear it
  task automatic run_inst(input int mode, input int due, input bit short_first, input int fails);
    int t;
    start_txn(due, mode);
    go_tender();
    if (short_first) begin
      push_ev(EV_ERR, 0, 0);
      tender(int'($urandom_range(0, due - 1)));
      check("short tender stays", bus.state_o, 4);
      check("short tender paid", bus.paid_total_o, 0);
    end
    for (int a = 0; a <= fails; a++) begin
      t = due + int'($urandom_range(0, 100));
      tender(t);
      wait_state(5, "inst enter validate");
      check("inst paid_total", bus.paid_total_o, t);
      if (a < fails) begin
        if (a + 1 == int'(MAXR)) begin
          push_ev(EV_REFUND, 0, t);
          verdict(1'b0, 1'b1);
          finish_refund();
          return;
        end
        verdict($urandom_range(0, 1) == 1, 1'b1);
        wait_state(4, "inst retry tender");
        check("inst paid cleared", bus.paid_total_o, 0);
      end else begin
        push_ev(EV_PRINT, t, 0);
        verdict(1'b1, 1'b0);
        finish_print();
      end
    end
  endtask

  task automatic run_cancel(input int due, input int tl[$]);
    longint sum = 0;
    start_txn(due, 0);
    go_tender();
    foreach (tl[i]) begin
      tender(tl[i]);
      sum += tl[i];
    end
    check("partial paid", bus.paid_total_o, sum);
    if (sum > 0) push_ev(EV_REFUND, 0, sum);
    bus.cancel_i = 1'b1; tick(); bus.cancel_i = 1'b0;
    if (sum > 0) finish_refund();
    else check_idle("cancel unpaid");
  endtask

  initial begin
    int tl[$];
    int n;
    int due;
    int s;
    int a;
    clear_inputs();
    #12;
    check_idle("reset");
    check("reset print", bus.print_bill_o, 0);
    check("reset refund", bus.refund_o, 0);
    check("reset error", bus.error_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    tl.delete(); tl.push_back(200); tl.push_back(200); tl.push_back(200);
    run_cash(500, tl, 0, 1'b0);

    start_txn(750, 2);
    go_tender();
    push_ev(EV_ERR, 0, 0);
    tender(700);
    check("card short stays", bus.state_o, 4);
    tender(750);
    wait_state(5, "card validate");
    push_ev(EV_PRINT, 750, 0);
    verdict(1'b1, 1'b0);
    finish_print();

    run_inst(1, 1200, 1'b0, 3);

    tl.delete(); tl.push_back(100);
    run_cancel(300, tl);
    tl.delete(); tl.push_back(100); tl.push_back(200);
    run_cash(300, tl, 0, 1'b1);

    // Zero bill is rejected at scan
    bus.voucher_placed_i = 1'b1; tick(); bus.voucher_placed_i = 1'b0;
    wait_state(1, "zero bill scan");
    push_ev(EV_ERR, 0, 0);
    bus.scan_ok_i = 1'b1; bus.bill_due_i = '0; tick(); bus.scan_ok_i = 1'b0;
    check_idle("zero bill");

    // Reserved mode rejected, then cancel with nothing paid goes straight home
    bus.voucher_placed_i = 1'b1; tick(); bus.voucher_placed_i = 1'b0;
    wait_state(1, "rsvd scan");
    bus.scan_ok_i = 1'b1; bus.bill_due_i = 16'd90; tick(); bus.scan_ok_i = 1'b0;
    wait_state(2, "rsvd select");
    push_ev(EV_ERR, 0, 0);
    bus.pay_mode_valid_i = 1'b1; bus.pay_mode_i = 2'b11; tick(); bus.pay_mode_valid_i = 1'b0;
    check("reserved mode stays", bus.state_o, 2);
    bus.cancel_i = 1'b1; tick(); bus.cancel_i = 1'b0;
    check_idle("cancel in select");

    // Stall in CONFIRM until the idle timeout aborts the transaction
    start_txn(400, 0);
    push_ev(EV_ERR, 0, 0);
    n = 0;
    while (bus.state_o == 3'd3 && n < 20) begin
      n++;
      tick();
    end
    check("timeout cycles in confirm", n, TMO);
    check_idle("after timeout");
    tick();

    // Asynchronous reset in the middle of a cash tender
    start_txn(500, 0);
    go_tender();
    tender(200);
    check("pre-reset paid", bus.paid_total_o, 200);
    #3 rst_n = 1'b0;
    #1;
    check_idle("async reset");
    check("async reset refund", bus.refund_o, 0);
    check("async reset print", bus.print_bill_o, 0);
    check("async reset error", bus.error_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          due = int'($urandom_range(1, 2000));
          tl.delete(); s = 0;
          while (s < due) begin
            a = int'($urandom_range(1, due));
            tl.push_back(a);
            s += a;
          end
          run_cash(due, tl, int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
        end
        1: run_inst(2, int'($urandom_range(2, 3000)), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 2)));
        2: run_inst(1, int'($urandom_range(2, 3000)), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 3)));
        default: begin
          due = int'($urandom_range(50, 2000));
          tl.delete(); s = 0;
          repeat ($urandom_range(0, 3)) begin
            a = int'($urandom_range(1, 15));
            tl.push_back(a);
            s += a;
          end
          run_cancel(due, tl);
        end
      endcase
      tick();
    end

    tick(); tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/atp_txn_ctrl.md
ATP_TXN_CTRL -- requirements
Module: atp_txn_ctrl

Interface
REQ-001 Parameter AMT_W, default 16, width of all amount ports in paise.
REQ-002 Parameter TIMEOUT_CYC, default 1000, idle cycles allowed in any waiting state before abort.
REQ-003 Parameter MAX_RETRY, default 3, validation failures allowed per transaction before refund.
REQ-004 clk  in  1  single clock, all state changes on rising edge.
REQ-005 rst  in  1  one clock; reset is asynchronous and active-low.
REQ-006 voucher_placed_i  in  1  voucher present pulse.
REQ-007 scan_ok_i  in  1  scan complete pulse; bill_due_i is valid in the same cycle.
REQ-008 bill_due_i  in  AMT_W  amount due read from voucher.
REQ-009 pay_mode_i  in  2  00 cash, 01 cheque, 10 card, 11 reserved; sampled with pay_mode_valid_i.
REQ-010 pay_mode_valid_i  in  1  payment mode selection strobe.
REQ-011 confirm_i  in  1  customer confirms displayed amount.
REQ-012 tender_valid_i / tender_amt_i  in  1 / AMT_W  one note, cheque or card authorisation and its value.
REQ-013 validate_ok_i / validate_fail_i  in  1 / 1  external validator verdict.
REQ-014 cancel_i  in  1  customer abort; bill_ack_i  in  1  printer accepted receipt.
REQ-015 state_o  out  3  current FSM state encoding per REQ-018.
REQ-016 amount_due_o  out  AMT_W; paid_total_o  out  AMT_W+1; change_o  out  AMT_W (change or refund amount).
REQ-017 print_bill_o  out  1 (level); refund_o  out  1 (one-cycle pulse); busy_o  out  1; error_o  out  1 (one-cycle pulse).

Function
REQ-018 FSM states SHALL be IDLE=0, SCAN=1, SELECT=2, CONFIRM=3, TENDER=4, VALIDATE=5, PRINT=6, REFUND=7.
REQ-019 IDLE -> SCAN on voucher_placed_i; SCAN -> SELECT on scan_ok_i, latching bill_due_i into amount_due_o.
REQ-020 SCAN with scan_ok_i and bill_due_i==0 SHALL pulse error_o and return to IDLE.
REQ-021 SELECT -> CONFIRM on pay_mode_valid_i with mode!=11; mode 11 SHALL pulse error_o and stay in SELECT.
REQ-022 CONFIRM -> TENDER on confirm_i.
REQ-023 TENDER, cash: each tender_valid_i adds tender_amt_i to paid_total_o, saturating at 2^(AMT_W+1)-1; when registered paid_total_o >= amount_due_o, next cycle -> VALIDATE.
REQ-024 TENDER, cheque/card: tender_valid_i with tender_amt_i >= amount_due_o loads paid_total_o and -> VALIDATE; smaller value pulses error_o, stays in TENDER, paid_total_o unchanged.
REQ-025 VALIDATE -> PRINT on validate_ok_i; change_o SHALL load paid_total_o - amount_due_o for cash, 0 for cheque/card.
REQ-026 VALIDATE on validate_fail_i: retry counter increments; if new count < MAX_RETRY, cheque/card return to TENDER with paid_total_o cleared, cash returns to TENDER keeping paid_total_o; if count reaches MAX_RETRY -> REFUND.
REQ-027 validate_ok_i and validate_fail_i together SHALL be treated as fail.
REQ-028 PRINT holds print_bill_o=1 until bill_ack_i, then -> IDLE clearing amount_due_o, paid_total_o, change_o, retry counter.
REQ-029 REFUND lasts one cycle: refund_o=1, change_o=paid_total_o truncated to AMT_W, then -> IDLE with all registers cleared.
REQ-030 cancel_i in SCAN..TENDER -> REFUND if paid_total_o>0, else IDLE; ignored in IDLE, VALIDATE, PRINT, REFUND.
REQ-031 Timeout counter resets on every state change and any accepted input; reaching TIMEOUT_CYC in SCAN..VALIDATE pulses error_o and acts as cancel; counter disabled in IDLE, PRINT, REFUND.
REQ-032 Priority per cycle: cancel_i > timeout > normal transition input.
REQ-033 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-034 rst low SHALL asynchronously force IDLE, all amount outputs 0, print_bill_o, refund_o, error_o 0, busy_o 0, retry and timeout counters 0, including mid-transaction with no refund pulse.

Verification
REQ-035 Cash: due=500, tenders 200,200,200, validate_ok -> paid_total_o=600, change_o=100, print_bill_o until bill_ack_i, then IDLE.
REQ-036 Card: due=750, tender 700 -> error_o pulse, stay TENDER; tender 750, validate_ok -> change_o=0, PRINT.
REQ-037 Cheque, MAX_RETRY=3: three validate_fail_i -> REFUND with refund_o one cycle, change_o=paid amount, then IDLE.
REQ-038 Cash due=300, tender 100, cancel_i -> REFUND, change_o=100; cancel in VALIDATE ignored.
REQ-039 TIMEOUT_CYC=8: stall 8 cycles in CONFIRM -> error_o pulse, IDLE, no refund_o.
REQ-040 rst low while in TENDER with paid_total_o=200 -> immediate IDLE, all outputs 0, no refund_o.
